// File: rtl/nested_loop_counter.sv
// nested_loop_counter: produces the index tuple of NLEV nested loops
// (level 0 innermost). Each accepted beat yields one tuple. Start, step and
// bound for every level are captured when a sweep begins. The block adds
// valid/ready back-pressure, abort, a one-cycle done pulse and a beat counter.
module nested_loop_counter #(
  parameter int NLEV = 3,
  parameter int W    = 8,
  parameter int CW   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [NLEV*W-1:0] i_cfg_start,
  input  logic [NLEV*W-1:0] i_cfg_step,
  input  logic [NLEV*W-1:0] i_cfg_bound,
  input  logic              i_ready,
  output logic [NLEV*W-1:0] o_idx,
  output logic              o_valid,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done,
  output logic [CW-1:0]     o_iter_cnt
);

  // state  | meaning
  // IDLE   | waiting for start; idx/iter_cnt hold results of the last sweep
  // RUN    | presenting tuples, advancing on each valid & ready beat
  // DONE   | one-cycle done pulse after the final tuple was accepted
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NLEV*W-1:0]   r_start;
  logic [NLEV*W-1:0]   r_step;
  logic [NLEV*W-1:0]   r_bound;
  logic [NLEV*W-1:0]   r_idx;
  logic [CW-1:0]       r_iter_cnt;

  logic [NLEV-1:0]     w_term;
  logic [NLEV*W-1:0]   w_idx_adv;
  logic                w_carry;
  logic [W:0]          w_sum;
  logic                w_all_term;
  logic                w_capture;
  logic                w_hs;
  logic                w_valid;
  logic                w_busy;
  logic                w_done;

  // Per-level terminal detection and ripple-carry advance of the tuple.
  // The sum is formed in W+1 bits so an overshooting step ends the level
  // instead of wrapping around.
  always_comb begin
    w_term    = '0;
    w_idx_adv = r_idx;
    w_carry   = 1'b1;
    w_sum     = '0;
    for (int l = 0; l < NLEV; l++) begin
      w_sum     = {1'b0, r_idx[l*W +: W]} + {1'b0, r_step[l*W +: W]};
      w_term[l] = (r_step[l*W +: W] == '0) || (w_sum > {1'b0, r_bound[l*W +: W]});
      if (w_carry) begin
        if (w_term[l]) begin
          w_idx_adv[l*W +: W] = r_start[l*W +: W];
        end else begin
          w_idx_adv[l*W +: W] = w_sum[W-1:0];
          w_carry             = 1'b0;
        end
      end
    end
  end

  assign w_all_term = &w_term;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and status decode; abort beats start and handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_hs        = 1'b0;
    w_valid     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_valid = 1'b1;
        w_busy  = 1'b1;
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_ready) begin
          w_hs = 1'b1;
          if (w_all_term) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config capture, tuple advance and beat counting. The final tuple is
  // held (not reloaded) so it remains visible after the sweep ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start    <= '0;
      r_step     <= '0;
      r_bound    <= '0;
      r_idx      <= '0;
      r_iter_cnt <= '0;
    end else if (w_capture) begin
      r_start    <= i_cfg_start;
      r_step     <= i_cfg_step;
      r_bound    <= i_cfg_bound;
      r_idx      <= i_cfg_start;
      r_iter_cnt <= '0;
    end else if (w_hs) begin
      r_iter_cnt <= r_iter_cnt + CW'(1);
      if (!w_all_term) r_idx <= w_idx_adv;
    end
  end

  assign o_idx      = r_idx;
  assign o_valid    = w_valid;
  assign o_last     = w_valid & w_all_term;
  assign o_busy     = w_busy;
  assign o_done     = w_done;
  assign o_iter_cnt = r_iter_cnt;

endmodule

// File: tb/tb_nested_loop_counter.sv
// Directed bench for nested_loop_counter (NLEV=3, W=8, CW=24).
module tb_nested_loop_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_abort, i_ready;
  logic [23:0] i_cfg_start, i_cfg_step, i_cfg_bound;
  logic [23:0] o_idx;
  logic        o_valid, o_last, o_busy, o_done;
  logic [23:0] o_iter_cnt;

  int total = 0;
  int bad   = 0;

  nested_loop_counter #(.NLEV(3), .W(8), .CW(24)) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_abort(i_abort),
    .i_cfg_start(i_cfg_start), .i_cfg_step(i_cfg_step), .i_cfg_bound(i_cfg_bound),
    .i_ready(i_ready),
    .o_idx(o_idx), .o_valid(o_valid), .o_last(o_last), .o_busy(o_busy),
    .o_done(o_done), .o_iter_cnt(o_iter_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] t3(input int a2, input int a1, input int a0);
    return {8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Tuple k of the 2x3x2 sweep (bound l2=1, l1=2, l0=1, step 1, start 0).
  function automatic logic [23:0] ka(input int k);
    return t3(k / 6, (k / 2) % 3, k % 2);
  endfunction

  task automatic do_start(input logic [23:0] s, input logic [23:0] st, input logic [23:0] b);
    i_cfg_start = s;
    i_cfg_step  = st;
    i_cfg_bound = b;
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
  endtask

  task automatic tup(input string tag, input logic [23:0] e, input logic e_last);
    chk({tag, "_idx"}, o_idx, e);
    chk({tag, "_last"}, o_last, e_last);
    chk({tag, "_valid"}, o_valid, 1'b1);
    tick();
  endtask

  task automatic fin(input string tag, input logic [23:0] e_idx, input int e_iter);
    chk({tag, "_done"}, o_done, 1'b1);
    chk({tag, "_valid0"}, o_valid, 1'b0);
    chk({tag, "_busy0"}, o_busy, 1'b0);
    chk({tag, "_iter"}, o_iter_cnt, 24'(e_iter));
    chk({tag, "_idxhold"}, o_idx, e_idx);
    tick();
    chk({tag, "_done0"}, o_done, 1'b0);
  endtask

  localparam logic [23:0] A_START = 24'h000000;
  localparam logic [23:0] A_STEP  = 24'h010101;
  localparam logic [23:0] A_BOUND = 24'h010201;

  initial begin
    rst = 1'b1;
    i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    i_cfg_start = '0; i_cfg_step = '0; i_cfg_bound = '0;
    #12;
    chk("rst_idx", o_idx, 24'h0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_iter", o_iter_cnt, 24'h0);
    rst = 1'b0;
    tick();

    // Full 12-tuple sweep with ready held high.
    i_ready = 1'b1;
    do_start(A_START, A_STEP, A_BOUND);
    chk("s1_busy", o_busy, 1'b1);
    for (int k = 0; k < 12; k++) tup($sformatf("s1_k%0d", k), ka(k), k == 11);
    fin("s1", t3(1, 2, 1), 12);

    // Single active level: 0,3,6 with bound 6 and with overshooting bound 7.
    do_start(24'h000000, 24'h000003, 24'h000006);
    tup("b6_0", t3(0, 0, 0), 1'b0);
    tup("b6_1", t3(0, 0, 3), 1'b0);
    tup("b6_2", t3(0, 0, 6), 1'b1);
    fin("b6", t3(0, 0, 6), 3);
    do_start(24'h000000, 24'h000003, 24'h000007);
    tup("b7_0", t3(0, 0, 0), 1'b0);
    tup("b7_1", t3(0, 0, 3), 1'b0);
    tup("b7_2", t3(0, 0, 6), 1'b1);
    fin("b7", t3(0, 0, 6), 3);

    // Start above bound, and zero step: one tuple each.
    do_start(24'h000005, 24'h000001, 24'h000002);
    tup("sgtb", t3(0, 0, 5), 1'b1);
    fin("sgtb", t3(0, 0, 5), 1);
    do_start(24'h000004, 24'h000000, 24'h000009);
    tup("step0", t3(0, 0, 4), 1'b1);
    fin("step0", t3(0, 0, 4), 1);

    // Back-pressure: stall 3 cycles while tuple 5 is presented.
    do_start(A_START, A_STEP, A_BOUND);
    for (int k = 0; k < 5; k++) tup($sformatf("bp_k%0d", k), ka(k), 1'b0);
    i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp_hold_idx%0d", c), o_idx, ka(5));
      chk($sformatf("bp_hold_iter%0d", c), o_iter_cnt, 24'd5);
      chk($sformatf("bp_hold_last%0d", c), o_last, 1'b0);
    end
    i_ready = 1'b1;
    for (int k = 5; k < 12; k++) tup($sformatf("bp_k%0d", k), ka(k), k == 11);
    fin("bp", t3(1, 2, 1), 12);

    // Abort on the 4th tuple together with ready.
    do_start(A_START, A_STEP, A_BOUND);
    for (int k = 0; k < 3; k++) tup($sformatf("ab_k%0d", k), ka(k), 1'b0);
    chk("ab_k3_idx", o_idx, ka(3));
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("ab_valid", o_valid, 1'b0);
    chk("ab_busy", o_busy, 1'b0);
    chk("ab_done", o_done, 1'b0);
    chk("ab_iter", o_iter_cnt, 24'd3);
    tick();
    chk("ab_done_late", o_done, 1'b0);
    do_start(A_START, A_STEP, A_BOUND);
    for (int k = 0; k < 12; k++) tup($sformatf("ab2_k%0d", k), ka(k), k == 11);
    fin("ab2", t3(1, 2, 1), 12);

    // Abort together with start in IDLE: sweep must not begin.
    i_abort = 1'b1;
    do_start(A_START, A_STEP, A_BOUND);
    i_abort = 1'b0;
    chk("abst_valid", o_valid, 1'b0);
    chk("abst_iter", o_iter_cnt, 24'd12);

    // Start during RUN with different cfg, then cfg left changed.
    do_start(A_START, A_STEP, A_BOUND);
    for (int k = 0; k < 2; k++) tup($sformatf("sr_k%0d", k), ka(k), 1'b0);
    i_cfg_start = 24'h030303; i_cfg_step = 24'h020202; i_cfg_bound = 24'hFFFFFF;
    i_start = 1'b1;
    tup("sr_k2", ka(2), 1'b0);
    i_start = 1'b0;
    for (int k = 3; k < 12; k++) tup($sformatf("sr_k%0d", k), ka(k), k == 11);
    fin("sr", t3(1, 2, 1), 12);

    // Asynchronous reset mid-sweep.
    do_start(A_START, A_STEP, A_BOUND);
    for (int k = 0; k < 4; k++) tup($sformatf("rs_k%0d", k), ka(k), 1'b0);
    rst = 1'b1;
    #1;
    chk("rs_idx", o_idx, 24'h0);
    chk("rs_valid", o_valid, 1'b0);
    chk("rs_busy", o_busy, 1'b0);
    chk("rs_last", o_last, 1'b0);
    chk("rs_done", o_done, 1'b0);
    chk("rs_iter", o_iter_cnt, 24'h0);
    #2;
    rst = 1'b0;
    tick();
    do_start(A_START, A_STEP, A_BOUND);
    for (int k = 0; k < 12; k++) tup($sformatf("rs2_k%0d", k), ka(k), k == 11);
    fin("rs2", t3(1, 2, 1), 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nested_loop_counter.md
Name: nested_loop_counter

Overview:
- Parametrised successor to the single-level step/goal counter with auto-reload.
- Generates the full index tuple of NLEV nested loops (level 0 innermost), one tuple per accepted beat, with per-level start/step/bound captured at start.
- Sits between the accelerator control FSM and the matrix operand/result address logic.
- Replaces hand-chained counters plus reload logic in the control unit; adds valid/ready back-pressure, abort, a done pulse and a beat counter.

Parameters:
- NLEV, 3, number of nested loop levels (>=1).
- W, 8, width of each level's index, start, step and bound.
- CW, 24, width of the beat counter iter_cnt.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  synchronous cancel; honoured in any state.
- cfg_start  input  NLEV*W  per-level initial value; level l at bits [l*W +: W].
- cfg_step  input  NLEV*W  per-level increment, same packing.
- cfg_bound  input  NLEV*W  per-level inclusive upper limit, same packing.
- ready  input  1  consumer accepts the current tuple.
- idx  output  NLEV*W  current index tuple, same packing.
- valid  output  1  idx is a valid tuple.
- last  output  1  current tuple is the final one of the sweep.
- busy  output  1  sweep in progress (RUN).
- done  output  1  one-cycle pulse after the final tuple is accepted.
- iter_cnt  output  CW  number of tuples accepted in the current or most recent sweep.

Behaviour:
- Reset: state IDLE. idx, valid, last, busy, done, iter_cnt and captured config all 0.
- States: IDLE, RUN, DONE.
- IDLE + start:
  - Capture cfg_* into internal registers and load idx[l] = cfg_start[l].
  - Clear iter_cnt and go to RUN; valid = busy = 1 from the next cycle.
  - Later changes to cfg_* have no effect until the next start.
- start outside IDLE is ignored.
- Terminal condition per level, term[l]:
  - step[l] == 0, or
  - idx[l] + step[l] > bound[l], compared unsigned in W+1 bits (so overshoot ends the level and no wrap-around occurs).
  - A level whose start > bound yields exactly one value (start).
- last = valid & all term[l].
- Advance on a handshake (valid & ready in RUN): evaluate levels 0..NLEV-1 with carry-in c0 = 1. For each level with carry-in:
  - if term[l], reload idx[l] = start[l] and pass carry;
  - else set idx[l] = idx[l] + step[l] and stop the carry.
- iter_cnt increments by 1 (mod 2^CW) on every handshake.
- No handshake (ready = 0): idx, valid, last and iter_cnt hold.
- Handshake with last = 1:
  - Next cycle: state DONE, valid = busy = 0, done = 1.
  - Cycle after: state IDLE, done = 0.
  - idx and iter_cnt keep their final values until the next start.
- Throughput: one tuple per cycle with ready held high. Latency from start to first valid is 1 cycle.
- abort:
  - In RUN or DONE: next cycle IDLE, valid = busy = done = 0, no done pulse; iter_cnt holds.
  - abort wins over a simultaneous handshake or start.
  - In IDLE, abort + start: abort wins and the sweep does not begin.
- Total tuples per sweep = product over levels of (floor((bound - start) / step) + 1), or 1 for degenerate levels.
- Asynchronous reset mid-sweep returns everything to reset values immediately.

Test Plan:
- NLEV=3, start 0/0/0, step 1/1/1, bound 1/2/1, ready = 1 → 12 tuples; level 0 toggles fastest, e.g. (l2,l1,l0) = (0,0,0), (0,0,1), (0,1,0) ... (1,2,1). last only on (1,2,1); done pulses 1 cycle later; iter_cnt = 12.
- Single active level: step 3, bound 6 from 0 gives 0, 3, 6. Bound 7 gives the same 0, 3, 6 (overshoot terminates). Start 5 > bound 2 gives one tuple, 5. step 0 gives one tuple, start.
- Back-pressure: ready low for 3 cycles mid-sweep → idx, last and iter_cnt stable; the sweep resumes with no skipped or duplicated tuple.
- abort asserted on the 4th tuple together with ready → next cycle IDLE, no done, iter_cnt = 3. A new start then sweeps from the configured start values.
- start pulsed during RUN with different cfg_* → ignored; the sweep completes with the original config. cfg_* changed after start → no effect.
- rst asserted mid-sweep → all outputs 0 without waiting for a clock edge. A following start behaves as in the first scenario.
